pio_mux_ctrl: RTL and testbench

Parametrised per-pin I/O multiplexer with a register interface for the MKR, NINA and PCIe pin banks. Per pin, it selects between a GPIO function (function 0, software-driven OUT/DIR) and up to pFUNCS-1 alternate peripheral functions, each with its own output enable. A programmable dead-time blanks a pin whenever its selection changes. It synchronises pin inputs and raises an edge interrupt. One instance per bank sits between the system interconnect and the bank's top-level tristate buffers (bPIN = oPIN_OE ? oPIN_OUT : 1'bZ).

---
 rtl/pio_mux_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pio_mux_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_mux_ctrl.sv
// Per-pin GPIO/alternate-function pad mux with dead-time blanking, input synchronisers and edge IRQ.
// Latency: pad outputs combinational from state, reads 1 cycle, IRQ registered; no backpressure.
module pio_mux_ctrl #(
  parameter int pPINS        = 32,
  parameter int pFUNCS       = 4,
  parameter int pDEADTIME    = 4,
  parameter int pSYNC_STAGES = 2
) (
  input  logic                     iCLK,
  input  logic                     iRESETn,
  input  logic [3:0]               iADDRESS,
  input  logic                     iWRITE,
  input  logic [31:0]              iWRITE_DATA,
  input  logic                     iREAD,
  output logic [31:0]              oREAD_DATA,
  input  logic [pPINS-1:0]         iPIN_IN,
  input  logic [pPINS*pFUNCS-1:0]  iALT_OUT,
  input  logic [pPINS*pFUNCS-1:0]  iALT_OE,
  output logic [pPINS-1:0]         oPIN_OUT,
  output logic [pPINS-1:0]         oPIN_OE,
  output logic                     oIRQ
);

  localparam int         pMSEL_BITS     = $clog2(pFUNCS);
  localparam int         cPINS_PER_WORD = 32 / pMSEL_BITS;
  localparam logic [3:0] cDEADTIME      = 4'(pDEADTIME);

  localparam logic [3:0] cADDR_IN       = 4'd0;
  localparam logic [3:0] cADDR_OUT      = 4'd1;
  localparam logic [3:0] cADDR_DIR      = 4'd2;
  localparam logic [3:0] cADDR_OUT_SET  = 4'd3;
  localparam logic [3:0] cADDR_OUT_CLR  = 4'd4;
  localparam logic [3:0] cADDR_RISE_EN  = 4'd5;
  localparam logic [3:0] cADDR_FALL_EN  = 4'd6;
  localparam logic [3:0] cADDR_IRQ_STAT = 4'd7;

  logic [pPINS-1:0]                   r_out;
  logic [pPINS-1:0]                   r_dir;
  logic [pPINS-1:0]                   r_rise_en;
  logic [pPINS-1:0]                   r_fall_en;
  logic [pPINS-1:0]                   r_stat;
  logic [pPINS-1:0][pMSEL_BITS-1:0]   r_msel;
  logic [pPINS-1:0][3:0]              r_dcnt;
  logic [pSYNC_STAGES-1:0][pPINS-1:0] r_sync;
  logic [pPINS-1:0]                   r_hist;

  logic [pPINS-1:0]                   w_wr_bits;
  logic [pPINS-1:0]                   w_in;
  logic [pPINS-1:0]                   w_rise;
  logic [pPINS-1:0]                   w_fall;
  logic [pPINS-1:0]                   w_stat_set;
  logic [pPINS-1:0]                   w_stat_clr;
  logic [pPINS-1:0]                   w_msel_chg;
  logic [pPINS-1:0][pMSEL_BITS-1:0]   w_msel_new;
  logic [3:0][31:0]                   w_msel_word;
  logic [31:0]                        w_rd_word;
  logic [pFUNCS-1:0][pPINS-1:0]       w_alt_out;
  logic [pFUNCS-1:0][pPINS-1:0]       w_alt_oe;

  assign w_wr_bits = iWRITE_DATA[pPINS-1:0];
  assign w_alt_out = iALT_OUT;
  assign w_alt_oe  = iALT_OE;

  // Software GPIO registers.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_out     <= '0;
      r_dir     <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
    end else if (iWRITE) begin
      case (iADDRESS)
        cADDR_OUT:     r_out     <= w_wr_bits;
        cADDR_DIR:     r_dir     <= w_wr_bits;
        cADDR_OUT_SET: r_out     <= r_out | w_wr_bits;
        cADDR_OUT_CLR: r_out     <= r_out & ~w_wr_bits;
        cADDR_RISE_EN: r_rise_en <= w_wr_bits;
        cADDR_FALL_EN: r_fall_en <= w_wr_bits;
        default: ;
      endcase
    end
  end

  // Input synchroniser chain followed by a history flop for edge detection.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_sync <= '0;
      r_hist <= '0;
    end else begin
      r_sync[0] <= iPIN_IN;
      for (int s = 1; s < pSYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
      r_hist <= r_sync[pSYNC_STAGES-1];
    end
  end

  assign w_in       = r_sync[pSYNC_STAGES-1];
  assign w_rise     = w_in & ~r_hist;
  assign w_fall     = ~w_in & r_hist;
  assign w_stat_set = (w_rise & r_rise_en) | (w_fall & r_fall_en);
  assign w_stat_clr = (iWRITE && (iADDRESS == cADDR_IRQ_STAT)) ? w_wr_bits : '0;

  // A new event in the same cycle as its W1C keeps the bit set.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_stat <= '0;
      oIRQ   <= 1'b0;
    end else begin
      r_stat <= (r_stat & ~w_stat_clr) | w_stat_set;
      oIRQ   <= |r_stat;
    end
  end

  always_comb begin
    w_msel_chg = '0;
    w_msel_new = '0;
    for (int i = 0; i < pPINS; i++) begin
      w_msel_new[i] = iWRITE_DATA[(i % cPINS_PER_WORD)*pMSEL_BITS +: pMSEL_BITS];
      w_msel_chg[i] = iWRITE && (iADDRESS == 4'(8 + i / cPINS_PER_WORD)) &&
                      (w_msel_new[i] != r_msel[i]);
    end
  end

  // The pin follows r_msel only once its dead-time counter has drained.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_msel <= '0;
      r_dcnt <= '0;
    end else begin
      for (int i = 0; i < pPINS; i++) begin
        if (w_msel_chg[i]) begin
          r_msel[i] <= w_msel_new[i];
          r_dcnt[i] <= cDEADTIME;
        end else if (r_dcnt[i] != 4'd0) begin
          r_dcnt[i] <= r_dcnt[i] - 4'd1;
        end
      end
    end
  end

  always_comb begin
    oPIN_OUT = '0;
    oPIN_OE  = '0;
    for (int i = 0; i < pPINS; i++) begin
      if (r_dcnt[i] == 4'd0) begin
        if (r_msel[i] == '0) begin
          oPIN_OUT[i] = r_out[i];
          oPIN_OE[i]  = r_dir[i];
        end else begin
          oPIN_OUT[i] = w_alt_out[r_msel[i]][i];
          oPIN_OE[i]  = w_alt_oe[r_msel[i]][i];
        end
      end
    end
  end

  always_comb begin
    w_msel_word = '0;
    for (int i = 0; i < pPINS; i++) begin
      w_msel_word[i / cPINS_PER_WORD][(i % cPINS_PER_WORD)*pMSEL_BITS +: pMSEL_BITS] = r_msel[i];
    end
  end

  always_comb begin
    w_rd_word = '0;
    case (iADDRESS)
      cADDR_IN:       w_rd_word[pPINS-1:0] = w_in;
      cADDR_OUT:      w_rd_word[pPINS-1:0] = r_out;
      cADDR_DIR:      w_rd_word[pPINS-1:0] = r_dir;
      cADDR_RISE_EN:  w_rd_word[pPINS-1:0] = r_rise_en;
      cADDR_FALL_EN:  w_rd_word[pPINS-1:0] = r_fall_en;
      cADDR_IRQ_STAT: w_rd_word[pPINS-1:0] = r_stat;
      4'd8, 4'd9, 4'd10, 4'd11: w_rd_word = w_msel_word[iADDRESS[1:0]];
      default: ;
    endcase
  end

  // Read data comes from pre-edge state, so a same-cycle write is not visible yet.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      oREAD_DATA <= '0;
    end else if (iREAD) begin
      oREAD_DATA <= w_rd_word;
    end
  end

endmodule

// File: tb/tb_pio_mux_ctrl.sv
// Directed bench for pio_mux_ctrl: a 32-pin/4-function bank and a 19-pin/16-function bank.
module tb_pio_mux_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;

  logic [3:0]   a_addr;
  logic         a_wr, a_rd;
  logic [31:0]  a_wdata, a_rdata;
  logic [31:0]  a_pin_in, a_pin_out, a_pin_oe;
  logic [127:0] a_alt_out, a_alt_oe;
  logic         a_irq;

  logic [3:0]   b_addr;
  logic         b_wr, b_rd;
  logic [31:0]  b_wdata, b_rdata;
  logic [18:0]  b_pin_in, b_pin_out, b_pin_oe;
  logic [303:0] b_alt_out, b_alt_oe;
  logic         b_irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] d;

  pio_mux_ctrl #(.pPINS(32), .pFUNCS(4), .pDEADTIME(4), .pSYNC_STAGES(2)) u_dut_a (
    .iCLK(clk), .iRESETn(rst_n), .iADDRESS(a_addr), .iWRITE(a_wr), .iWRITE_DATA(a_wdata),
    .iREAD(a_rd), .oREAD_DATA(a_rdata), .iPIN_IN(a_pin_in), .iALT_OUT(a_alt_out),
    .iALT_OE(a_alt_oe), .oPIN_OUT(a_pin_out), .oPIN_OE(a_pin_oe), .oIRQ(a_irq)
  );

  pio_mux_ctrl #(.pPINS(19), .pFUNCS(16), .pDEADTIME(0), .pSYNC_STAGES(2)) u_dut_b (
    .iCLK(clk), .iRESETn(rst_n), .iADDRESS(b_addr), .iWRITE(b_wr), .iWRITE_DATA(b_wdata),
    .iREAD(b_rd), .oREAD_DATA(b_rdata), .iPIN_IN(b_pin_in), .iALT_OUT(b_alt_out),
    .iALT_OE(b_alt_oe), .oPIN_OUT(b_pin_out), .oPIN_OE(b_pin_oe), .oIRQ(b_irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [3:0] ad, input logic [31:0] dt);
    a_addr = ad; a_wdata = dt; a_wr = 1'b1;
    tick();
    a_wr = 1'b0;
  endtask

  task automatic rd_a(input logic [3:0] ad, output logic [31:0] dt);
    a_addr = ad; a_rd = 1'b1;
    tick();
    a_rd = 1'b0;
    dt = a_rdata;
  endtask

  task automatic wr_b(input logic [3:0] ad, input logic [31:0] dt);
    b_addr = ad; b_wdata = dt; b_wr = 1'b1;
    tick();
    b_wr = 1'b0;
  endtask

  task automatic rd_b(input logic [3:0] ad, output logic [31:0] dt);
    b_addr = ad; b_rd = 1'b1;
    tick();
    b_rd = 1'b0;
    dt = b_rdata;
  endtask

  initial begin
    rst_n = 1'b0;
    a_addr = '0; a_wr = 1'b0; a_rd = 1'b0; a_wdata = '0; a_pin_in = '0;
    a_alt_out = '0; a_alt_oe = '0;
    b_addr = '0; b_wr = 1'b0; b_rd = 1'b0; b_wdata = '0; b_pin_in = '0;
    b_alt_out = '0; b_alt_oe = '0;
    // Pin 1: f1 drives 1/oe 1, f2 drives 0/oe 1. Bank B pin 18: f15 drives 1/oe 1.
    a_alt_out[33] = 1'b1; a_alt_oe[33] = 1'b1;
    a_alt_oe[65]  = 1'b1;
    b_alt_out[303] = 1'b1; b_alt_oe[303] = 1'b1;

    repeat (3) tick();
    chk("rst_oe", a_pin_oe, 32'h0);
    chk("rst_out", a_pin_out, 32'h0);
    chk("rst_rdata", a_rdata, 32'h0);
    chk("rst_irq", a_irq, 32'h0);
    rst_n = 1'b1;
    tick();

    // GPIO path
    wr_a(4'd1, 32'h5);
    chk("out_immediate", a_pin_out[2:0], 32'h5);
    chk("oe_still_off", a_pin_oe[2:0], 32'h0);
    wr_a(4'd2, 32'h7);
    chk("gpio_out", a_pin_out[2:0], 32'h5);
    chk("gpio_oe", a_pin_oe[2:0], 32'h7);
    wr_a(4'd3, 32'h2);
    wr_a(4'd4, 32'h1);
    rd_a(4'd1, d);
    chk("out_set_clr", d, 32'h6);
    rd_a(4'd3, d);
    chk("out_set_reads0", d, 32'h0);
    a_addr = 4'd1; a_wdata = 32'h4; a_wr = 1'b1; a_rd = 1'b1;
    tick();
    a_wr = 1'b0; a_rd = 1'b0;
    chk("rd_wr_same_pre", a_rdata, 32'h6);
    rd_a(4'd1, d);
    chk("rd_wr_same_post", d, 32'h4);

    // Dead-time: pin 1 to f1, blanked exactly 4 cycles, pin 0 unaffected
    wr_a(4'd8, 32'h4);
    for (int k = 0; k < 4; k++) begin
      chk("t1_blank", {a_pin_oe[1], a_pin_out[1]}, 32'h0);
      chk("t1_pin0", {a_pin_oe[0], a_pin_out[0]}, 32'h2);
      tick();
    end
    chk("t1_f1_drives", {a_pin_oe[1], a_pin_out[1]}, 32'h3);
    chk("t1_pin0_after", {a_pin_oe[0], a_pin_out[0]}, 32'h2);
    rd_a(4'd8, d);
    chk("msel_read", d, 32'h4);

    // Back to GPIO
    wr_a(4'd8, 32'h0);
    repeat (4) tick();
    chk("back_gpio", {a_pin_oe[1], a_pin_out[1]}, 32'h2);
    wr_a(4'd2, 32'h5);

    // Reselect during blanking: f1 then f2 two cycles in
    wr_a(4'd8, 32'h4);
    chk("t2_blank0", {a_pin_oe[1], a_pin_out[1]}, 32'h0);
    tick();
    chk("t2_blank1", {a_pin_oe[1], a_pin_out[1]}, 32'h0);
    wr_a(4'd8, 32'h8);
    for (int k = 0; k < 4; k++) begin
      chk("t2_blank_ext", {a_pin_oe[1], a_pin_out[1]}, 32'h0);
      tick();
    end
    chk("t2_f2_drives", {a_pin_oe[1], a_pin_out[1]}, 32'h2);
    wr_a(4'd8, 32'h8);
    chk("unchanged_no_blank", {a_pin_oe[1], a_pin_out[1]}, 32'h2);

    // Rising-edge interrupt on pin 3
    wr_a(4'd5, 32'h8);
    a_pin_in[3] = 1'b1;
    tick();
    tick();
    rd_a(4'd0, d);
    chk("in_sync", d, 32'h8);
    chk("irq_not_yet", a_irq, 32'h0);
    rd_a(4'd7, d);
    chk("stat_rise", d, 32'h8);
    chk("irq_set", a_irq, 32'h1);
    wr_a(4'd7, 32'h8);
    tick();
    chk("irq_cleared", a_irq, 32'h0);

    a_pin_in[3] = 1'b0;
    repeat (4) tick();
    rd_a(4'd7, d);
    chk("fall_disabled", d, 32'h0);

    a_pin_in[3] = 1'b1;
    tick();
    tick();
    wr_a(4'd7, 32'h8);
    rd_a(4'd7, d);
    chk("set_beats_w1c", d, 32'h8);
    wr_a(4'd7, 32'h8);
    rd_a(4'd7, d);
    chk("w1c_clears", d, 32'h0);

    // Enabling rise with the pin already high must not raise status
    wr_a(4'd5, 32'h0);
    a_pin_in[3] = 1'b0;
    repeat (4) tick();
    a_pin_in[3] = 1'b1;
    repeat (4) tick();
    wr_a(4'd5, 32'h8);
    repeat (3) tick();
    rd_a(4'd7, d);
    chk("en_while_high", d, 32'h0);
    chk("en_while_high_irq", a_irq, 32'h0);

    // Falling edge with FALL_EN set
    wr_a(4'd6, 32'h8);
    wr_a(4'd5, 32'h0);
    a_pin_in[3] = 1'b0;
    repeat (3) tick();
    rd_a(4'd7, d);
    chk("stat_fall", d, 32'h8);
    wr_a(4'd7, 32'h8);
    wr_a(4'd6, 32'h0);

    // Reset in the middle of blanking, pin 3 held high through release
    a_pin_in[3] = 1'b1;
    wr_a(4'd8, 32'h4);
    tick();
    rd_a(4'd1, d);
    chk("out_before_rst", d, 32'h4);
    rst_n = 1'b0;
    #2;
    chk("midrst_oe", a_pin_oe, 32'h0);
    chk("midrst_out", a_pin_out, 32'h0);
    chk("midrst_rdata", a_rdata, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    wr_a(4'd2, 32'h2);
    chk("post_rst_gpio_oe", a_pin_oe, 32'h2);
    chk("post_rst_gpio_out", a_pin_out, 32'h0);
    repeat (4) tick();
    rd_a(4'd7, d);
    chk("rst_release_rise_dropped", d, 32'h0);
    chk("rst_release_irq", a_irq, 32'h0);

    // Bank B: 19 pins, 16 functions, zero dead-time
    wr_b(4'd10, 32'h0000_0F00);
    chk("b_f15_oe", b_pin_oe, 32'h4_0000);
    chk("b_f15_out", b_pin_out, 32'h4_0000);
    wr_b(4'd2, 32'hFFFF_FFFF);
    rd_b(4'd2, d);
    chk("b_dir_mask", d, 32'h0007_FFFF);
    chk("b_oe_all", b_pin_oe, 32'h0007_FFFF);
    wr_b(4'd8, 32'hFFFF_FFFF);
    rd_b(4'd8, d);
    chk("b_msel8", d, 32'hFFFF_FFFF);
    wr_b(4'd9, 32'h1234_5678);
    rd_b(4'd9, d);
    chk("b_msel9", d, 32'h1234_5678);
    rd_b(4'd10, d);
    chk("b_msel10", d, 32'h0000_0F00);
    wr_b(4'd11, 32'hFFFF_FFFF);
    rd_b(4'd11, d);
    chk("b_msel11_zero", d, 32'h0);
    wr_b(4'd10, 32'hFFFF_FFFF);
    rd_b(4'd10, d);
    chk("b_msel10_mask", d, 32'h0000_0FFF);
    rd_b(4'd12, d);
    chk("b_addr12_zero", d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
